// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package fetch_stage_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_STEP   = 32'd4;
  localparam int          IF_ID_W   = 65;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    DISCARD = 2'd1,
    STALLED = 2'd2
  } fetch_state_e;

  // IF/ID pipeline bundle: valid flag, instruction word, sequential PC.
  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
  } if_id_t;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush (load NOP/invalid) beats hold beats load.
// Latency: 1 cycle from d to q.
// Backpressure: hold freezes the contents; flush overrides hold.
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   flush       load {valid=0, NOP_WORD, pc=0}
//   hold        keep current contents
//   d / q       65-bit IF/ID bundle {valid, instr, pc}
module if_id_reg import fetch_stage_pkg::*; #(
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 hold,
  input  logic [IF_ID_W-1:0]   d,
  output logic [IF_ID_W-1:0]   q
);

  if_id_t ifid_q;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      ifid_q.valid <= 1'b0;
      ifid_q.instr <= NOP_WORD;
      ifid_q.pc    <= 32'h0;
    end else if (!hold) begin
      ifid_q <= if_id_t'(d);
    end
  end

  assign q = ifid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with PC, imem req/ready handshake, redirect and IF/ID register.
// Latency: imem_ready to IF_valid in 1 cycle; zero-wait memory sustains 1 instr/cycle.
// Backpressure: freeze parks one returned word in a skid register and drops imem_req.
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   freeze                   decode stall, IF/ID holds
//   Br_taken, Br_addr        downstream-resolved redirect
//   imem_req/addr/ready/rdata  variable-latency instruction memory handshake
//   IF_Instruction, IF_PC, IF_valid  IF/ID outputs to decode
module fetch_stage import fetch_stage_pkg::*; #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] PC_STEP   = fetch_stage_pkg::PC_STEP,
  parameter logic [31:0] NOP_INSTR = fetch_stage_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        Br_taken,
  input  logic [31:0] Br_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_Instruction,
  output logic [31:0] IF_PC,
  output logic        IF_valid
);

  fetch_state_e state;
  logic [31:0]  pc;
  logic [31:0]  pc_plus;
  logic [31:0]  redirect_pc;
  logic         skid_vld;
  logic [31:0]  skid_instr;
  logic [31:0]  skid_pc;
  logic         ack;

  logic         ifid_flush;
  logic         ifid_hold;
  if_id_t       ifid_d;
  if_id_t       ifid_q;

  // pc is only updated when a request completes or a redirect lands, so it
  // doubles as the stable request address, including the old address in DISCARD.
  assign imem_addr = pc;
  assign pc_plus   = pc + PC_STEP;
  // Ready only counts while a request is actually presented.
  assign ack       = imem_req & imem_ready;

  // IF/ID write control.
  always_comb begin
    ifid_flush   = 1'b0;
    ifid_hold    = 1'b0;
    ifid_d.valid = 1'b1;
    ifid_d.instr = imem_rdata;
    ifid_d.pc    = pc_plus;
    case (state)
      FETCH: begin
        if (Br_taken)  ifid_flush = 1'b1;
        else if (freeze) ifid_hold = 1'b1;
        else if (!ack) ifid_flush = 1'b1;  // bubble while waiting
      end
      DISCARD: begin
        ifid_flush = 1'b1;
      end
      STALLED: begin
        if (Br_taken)    ifid_flush = 1'b1;
        else if (freeze) ifid_hold  = 1'b1;
        else begin
          ifid_d.valid = skid_vld;
          ifid_d.instr = skid_instr;
          ifid_d.pc    = skid_pc;
        end
      end
      default: begin
        ifid_flush = 1'b1;
      end
    endcase
  end

  // FSM, PC, redirect target and skid buffer. imem_req is registered and
  // tracks the next state: low only in STALLED and during reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      redirect_pc <= 32'h0;
      skid_vld    <= 1'b0;
      skid_instr  <= NOP_INSTR;
      skid_pc     <= 32'h0;
      imem_req    <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          imem_req <= 1'b1;
          if (Br_taken) begin
            if (ack || !imem_req) begin
              // Nothing outstanding: redirect immediately.
              pc <= Br_addr;
            end else begin
              redirect_pc <= Br_addr;
              state       <= DISCARD;
            end
          end else if (ack) begin
            pc <= pc_plus;
            if (freeze) begin
              skid_vld   <= 1'b1;
              skid_instr <= imem_rdata;
              skid_pc    <= pc_plus;
              state      <= STALLED;
              imem_req   <= 1'b0;
            end
          end
        end

        DISCARD: begin
          imem_req <= 1'b1;
          if (Br_taken) redirect_pc <= Br_addr;
          if (imem_ready) begin
            // Youngest redirect wins when it coincides with completion.
            pc    <= Br_taken ? Br_addr : redirect_pc;
            state <= FETCH;
          end
        end

        STALLED: begin
          if (Br_taken) begin
            pc         <= Br_addr;
            skid_vld   <= 1'b0;
            skid_instr <= NOP_INSTR;
            skid_pc    <= 32'h0;
            state      <= FETCH;
            imem_req   <= 1'b1;
          end else if (!freeze) begin
            skid_vld   <= 1'b0;
            skid_instr <= NOP_INSTR;
            skid_pc    <= 32'h0;
            state      <= FETCH;
            imem_req   <= 1'b1;
          end else begin
            imem_req <= 1'b0;
          end
        end

        default: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end
      endcase
    end
  end

  if_id_reg #(
    .NOP_WORD (NOP_INSTR)
  ) u_if_id (
    .clk   (clk),
    .rst   (rst),
    .flush (ifid_flush),
    .hold  (ifid_hold),
    .d     (ifid_d),
    .q     (ifid_q)
  );

  assign IF_valid       = ifid_q.valid;
  assign IF_Instruction = ifid_q.instr;
  assign IF_PC          = ifid_q.pc;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, zero-wait, wait states, freeze/skid,
// branch redirects through DISCARD and STALLED, reset mid-wait, PC wrap.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        Br_taken;
  logic [31:0] Br_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] IF_Instruction;
  logic [31:0] IF_PC;
  logic        IF_valid;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Instruction memory contents: a recognisable word per address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .freeze         (freeze),
    .Br_taken       (Br_taken),
    .Br_addr        (Br_addr),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .IF_Instruction (IF_Instruction),
    .IF_PC          (IF_PC),
    .IF_valid       (IF_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset, release, and advance to the first cycle with imem_req=1 at RESET_PC.
  task automatic restart();
    rst = 1'b1; freeze = 1'b0; Br_taken = 1'b0; Br_addr = 32'h0; imem_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; freeze = 1'b0; Br_taken = 1'b0; Br_addr = 32'h0; imem_ready = 1'b0;
    step(); step(); step();
    chk("rst_req",   {31'h0, imem_req}, 32'h0);
    chk("rst_valid", {31'h0, IF_valid}, 32'h0);
    chk("rst_instr", IF_Instruction, 32'h0);
    chk("rst_pc",    IF_PC, 32'h0);

    // Zero-wait memory.
    rst = 1'b0;
    step();
    chk("zw_req1",   {31'h0, imem_req}, 32'h1);
    chk("zw_addr1",  imem_addr, 32'h0);
    chk("zw_valid1", {31'h0, IF_valid}, 32'h0);
    imem_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("zw_valid", {31'h0, IF_valid}, 32'h1);
      chk("zw_pc",    IF_PC, 32'(4 * i));
      chk("zw_instr", IF_Instruction, mem_word(32'(4 * (i - 1))));
    end

    // Two wait states on the second fetch.
    restart();
    imem_ready = 1'b1;
    step();
    chk("ws_pc0", IF_PC, 32'h4);
    chk("ws_addr0", imem_addr, 32'h4);
    imem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("ws_addr_wait",  imem_addr, 32'h4);
      chk("ws_valid_wait", {31'h0, IF_valid}, 32'h0);
    end
    imem_ready = 1'b1;
    step();
    chk("ws_valid", {31'h0, IF_valid}, 32'h1);
    chk("ws_instr", IF_Instruction, mem_word(32'h4));
    chk("ws_pc",    IF_PC, 32'h8);

    // Freeze for three cycles with ready=1: one word parked in the skid.
    restart();
    imem_ready = 1'b1;
    step();
    chk("fz_pc0", IF_PC, 32'h4);
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("fz_req",   {31'h0, imem_req}, 32'h0);
      chk("fz_hold",  IF_PC, 32'h4);
      chk("fz_instr", IF_Instruction, mem_word(32'h0));
    end
    freeze = 1'b0;
    step();
    chk("fz_skid_instr", IF_Instruction, mem_word(32'h4));
    chk("fz_skid_pc",    IF_PC, 32'h8);
    chk("fz_req_back",   {31'h0, imem_req}, 32'h1);
    chk("fz_addr_next",  imem_addr, 32'h8);
    step();
    chk("fz_next_instr", IF_Instruction, mem_word(32'h8));
    chk("fz_next_pc",    IF_PC, 32'hC);

    // Branch while a request waits: DISCARD keeps the old address.
    restart();
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0; Br_taken = 1'b1; Br_addr = 32'h40;
    step();
    Br_taken = 1'b0;
    chk("br_valid_flush", {31'h0, IF_valid}, 32'h0);
    chk("br_addr_old",    imem_addr, 32'h4);
    chk("br_req",         {31'h0, imem_req}, 32'h1);
    step();
    chk("br_addr_old2",   imem_addr, 32'h4);
    imem_ready = 1'b1;
    step();
    chk("br_addr_new",    imem_addr, 32'h40);
    chk("br_drop_valid",  {31'h0, IF_valid}, 32'h0);
    chk("br_drop_instr",  IF_Instruction, 32'h0);
    step();
    chk("br_tgt_instr",   IF_Instruction, mem_word(32'h40));
    chk("br_tgt_pc",      IF_PC, 32'h44);

    // Branch together with freeze while STALLED.
    restart();
    imem_ready = 1'b1;
    step();
    freeze = 1'b1;
    step();
    chk("bs_stalled_req", {31'h0, imem_req}, 32'h0);
    Br_taken = 1'b1; Br_addr = 32'h80;
    step();
    chk("bs_valid", {31'h0, IF_valid}, 32'h0);
    chk("bs_instr", IF_Instruction, 32'h0);
    chk("bs_addr",  imem_addr, 32'h80);
    chk("bs_req",   {31'h0, imem_req}, 32'h1);
    Br_taken = 1'b0; freeze = 1'b0;
    step();
    chk("bs_tgt_instr", IF_Instruction, mem_word(32'h80));
    chk("bs_tgt_pc",    IF_PC, 32'h84);

    // Reset in the middle of a wait.
    restart();
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    step();
    rst = 1'b1;
    step();
    chk("rm_req",   {31'h0, imem_req}, 32'h0);
    chk("rm_valid", {31'h0, IF_valid}, 32'h0);
    rst = 1'b0;
    step();
    chk("rm_req_back", {31'h0, imem_req}, 32'h1);
    chk("rm_addr",     imem_addr, 32'h0);
    imem_ready = 1'b1;
    step();
    chk("rm_pc", IF_PC, 32'h4);

    // PC wrap at the top of the address space.
    Br_taken = 1'b1; Br_addr = 32'hFFFF_FFFC;
    step();
    Br_taken = 1'b0;
    chk("wr_addr", imem_addr, 32'hFFFF_FFFC);
    step();
    chk("wr_pc",    IF_PC, 32'h0);
    chk("wr_instr", IF_Instruction, mem_word(32'hFFFF_FFFC));
    chk("wr_addr0", imem_addr, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
